// File: rtl/mem_responder_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder_pkg
//  Description : Shared types for the memory responder. It defines the
//                responder FSM states, the captured operation kinds, and a
//                helper that decodes the read/write strobes into an operation.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_responder_pkg;

    // Width of the latency counter. LATENCY is legal only in 1..15.
    localparam int c_CNT_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } mem_resp_state_t;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_ERR   = 2'd2
    } mem_op_t;

    // When both strobes are high, the request is an error transaction.
    function automatic mem_op_t decode_op(input logic rd, input logic wr);
        mem_op_t op;
        if (rd && wr) begin
            op = OP_ERR;
        end else if (wr) begin
            op = OP_WRITE;
        end else begin
            op = OP_READ;
        end
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_responder_be_sram.sv
`default_nettype none
// ============================================================================
//  Module      : be_sram
//  Description : A 2^ADDR_WIDTH x 32 SRAM. Each byte lane has its own write
//                enable. The read is synchronous, and its output register
//                holds the last word read. The storage has no reset.
//  Ports       : clk      - clock
//                i_we     - write enable (qualified per lane by i_be)
//                i_re     - read enable; loads o_rdata on the edge
//                i_addr   - word index
//                i_wdata  - write data
//                i_be     - byte lane enables
//                o_rdata  - registered read data
//  Revision    : 1.0 - initial release
// ============================================================================
module be_sram #(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  i_we,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic [31:0]           i_wdata,
    input  logic [3:0]            i_be,
    output logic [31:0]           o_rdata
);

    localparam int c_DEPTH = 1 << ADDR_WIDTH;

    // Each lane has its own array. As a result, every array has a single
    // writer process.
    for (genvar g = 0; g < 4; g++) begin : g_lane
        logic [7:0] r_mem [c_DEPTH];
        logic [7:0] r_q;

        always_ff @(posedge clk) begin
            if (i_we && i_be[g]) begin
                r_mem[i_addr] <= i_wdata[8*g +: 8];
            end
            if (i_re) begin
                r_q <= r_mem[i_addr];
            end
        end

        assign o_rdata[8*g +: 8] = r_q;
    end

endmodule
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : mem_responder
//  Description : Memory-side responder with a fixed response latency. The
//                block captures one read or write request in IDLE and counts
//                LATENCY cycles. At the edge that enters RESP, it commits the
//                write or reads the array. It then raises mem_resp for one
//                cycle.
//  Ports       : clk             - clock
//                rst             - asynchronous reset, active low
//                mem_read        - read request
//                mem_write       - write request
//                mem_address     - byte address ([1:0] ignored)
//                mem_wdata       - write data
//                mem_byte_enable - write lane enables
//                mem_rdata       - read data, held until the next read response
//                mem_resp        - one-cycle completion pulse
//                mem_err         - error flag, valid with mem_resp
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = 10,   // legal 1..29
    parameter int LATENCY    = 3     // legal 1..15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_address,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_byte_enable,
    output logic [31:0] mem_rdata,
    output logic        mem_resp,
    output logic        mem_err
);

    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(LATENCY - 1);

    mem_resp_state_t        r_state, w_state_next;
    logic [c_CNT_W-1:0]     r_cnt, w_cnt_next;
    logic                   w_capture;

    mem_op_t                r_op;
    logic [ADDR_WIDTH-1:0]  r_idx;
    logic [31:0]            r_wdata;
    logic [3:0]             r_be;
    logic                   r_oor;
    logic [31:0]            r_rdata;

    logic                   w_req;
    mem_op_t                w_req_op;
    logic                   w_in_oor;
    logic [ADDR_WIDTH-1:0]  w_in_idx;

    logic                   w_live;
    logic                   w_enter_resp;
    mem_op_t                w_sram_op;
    logic                   w_sram_oor;
    logic [ADDR_WIDTH-1:0]  w_sram_idx;
    logic [31:0]            w_sram_wdata;
    logic [3:0]             w_sram_be;
    logic                   w_sram_we;
    logic                   w_sram_re;
    logic [31:0]            w_sram_q;
    logic [31:0]            w_rd_word;
    logic [1:0]             w_unused_addr_bits;

    assign w_unused_addr_bits = mem_address[1:0];

    assign w_req    = mem_read | mem_write;
    assign w_req_op = decode_op(mem_read, mem_write);
    assign w_in_oor = |mem_address[31:ADDR_WIDTH+2];
    assign w_in_idx = mem_address[ADDR_WIDTH+1:2];

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_capture    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_capture    = 1'b1;
                    w_cnt_next   = c_CNT_LOAD;
                    w_state_next = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                // The counter leaves BUSY on the edge that takes it to zero.
                // As a result, mem_resp lands exactly LATENCY cycles after
                // the capture edge.
                w_cnt_next = r_cnt - 1'b1;
                if (r_cnt <= c_CNT_W'(1)) begin
                    w_state_next = RESP;
                end
            end
            RESP: begin
                w_cnt_next   = '0;
                w_state_next = IDLE;
            end
            default: begin
                w_cnt_next   = '0;
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // ------------------------------------------------------------------
    // Request capture and held read data
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op    <= OP_READ;
            r_idx   <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_oor   <= 1'b0;
            r_rdata <= '0;
        end else begin
            if (w_capture) begin
                r_op    <= w_req_op;
                r_idx   <= w_in_idx;
                r_wdata <= mem_wdata;
                r_be    <= mem_byte_enable;
                r_oor   <= w_in_oor;
            end
            if (r_state == RESP && r_op == OP_READ) begin
                r_rdata <= w_rd_word;
            end
        end
    end

    // ------------------------------------------------------------------
    // Array access on the edge entering RESP. With LATENCY=1 that edge is
    // also the capture edge, so the live inputs drive the array.
    // ------------------------------------------------------------------
    assign w_live       = (r_state == IDLE);
    assign w_enter_resp = (w_state_next == RESP) && (r_state != RESP);
    assign w_sram_op    = w_live ? w_req_op        : r_op;
    assign w_sram_oor   = w_live ? w_in_oor        : r_oor;
    assign w_sram_idx   = w_live ? w_in_idx        : r_idx;
    assign w_sram_wdata = w_live ? mem_wdata       : r_wdata;
    assign w_sram_be    = w_live ? mem_byte_enable : r_be;

    // Gate the enables with rst. This stops an access from reaching the
    // array while reset is held.
    assign w_sram_we = rst && w_enter_resp && (w_sram_op == OP_WRITE) && !w_sram_oor;
    assign w_sram_re = rst && w_enter_resp && (w_sram_op == OP_READ)  && !w_sram_oor;

    be_sram #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_sram (
        .clk     (clk),
        .i_we    (w_sram_we),
        .i_re    (w_sram_re),
        .i_addr  (w_sram_idx),
        .i_wdata (w_sram_wdata),
        .i_be    (w_sram_be),
        .o_rdata (w_sram_q)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_rd_word = r_oor ? 32'h0 : w_sram_q;
    assign mem_resp  = (r_state == RESP);
    assign mem_err   = mem_resp && ((r_op == OP_ERR) || r_oor);
    assign mem_rdata = (mem_resp && r_op == OP_READ) ? w_rd_word : r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_responder
//  Description : Self-checking bench for mem_responder. The bench uses one
//                instance with LATENCY=3 and one with LATENCY=1. Each request
//                pushes its expected response into a queue. The bench pops
//                that entry and compares it when mem_resp appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_responder;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk;
    logic        rst;

    logic        mem_read, mem_write;
    logic [31:0] mem_address, mem_wdata, mem_rdata;
    logic [3:0]  mem_byte_enable;
    logic        mem_resp, mem_err;

    logic        mem_read_1, mem_write_1;
    logic [31:0] mem_address_1, mem_wdata_1, mem_rdata_1;
    logic [3:0]  mem_byte_enable_1;
    logic        mem_resp_1, mem_err_1;

    int checks   = 0;
    int failures = 0;

    exp_t        sb[$];
    logic [31:0] sb1[$];

    mem_responder #(.ADDR_WIDTH(10), .LATENCY(3)) dut (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_address     (mem_address),
        .mem_wdata       (mem_wdata),
        .mem_byte_enable (mem_byte_enable),
        .mem_rdata       (mem_rdata),
        .mem_resp        (mem_resp),
        .mem_err         (mem_err)
    );

    mem_responder #(.ADDR_WIDTH(10), .LATENCY(1)) dut1 (
        .clk             (clk),
        .rst             (rst),
        .mem_read        (mem_read_1),
        .mem_write       (mem_write_1),
        .mem_address     (mem_address_1),
        .mem_wdata       (mem_wdata_1),
        .mem_byte_enable (mem_byte_enable_1),
        .mem_rdata       (mem_rdata_1),
        .mem_resp        (mem_resp_1),
        .mem_err         (mem_err_1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // Drives one request on the LATENCY=3 instance in an IDLE cycle and holds
    // it until mem_resp. It then checks latency, error, read data and the
    // single-cycle pulse.
    task automatic req3(input string tag, input logic rd, input logic wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input logic [31:0] exp_rdata,
                        input logic exp_err);
        exp_t e;
        int   n;
        bit   got;
        e.rdata = exp_rdata;
        e.err   = exp_err;
        sb.push_back(e);
        @(negedge clk);
        mem_read        = rd;
        mem_write       = wr;
        mem_address     = addr;
        mem_wdata       = wdata;
        mem_byte_enable = be;
        @(posedge clk);
        n   = 0;
        got = 0;
        while (!got && n < 20) begin
            @(negedge clk);
            n++;
            if (mem_resp === 1'b1) got = 1;
        end
        mem_read  = 1'b0;
        mem_write = 1'b0;
        e = sb.pop_front();
        if (!got) begin
            check({tag, "_timeout"}, 32'(n), 32'd3);
        end else begin
            check({tag, "_lat"},   32'(n),        32'd3);
            check({tag, "_err"},   32'(mem_err),  32'(e.err));
            check({tag, "_rdata"}, mem_rdata,     e.rdata);
            @(negedge clk);
            check({tag, "_pulse"}, 32'(mem_resp), 32'd0);
        end
    endtask

    initial begin
        rst = 1'b0;
        mem_read = 0; mem_write = 0; mem_address = 0; mem_wdata = 0; mem_byte_enable = 0;
        mem_read_1 = 0; mem_write_1 = 0; mem_address_1 = 0; mem_wdata_1 = 0; mem_byte_enable_1 = 0;
        repeat (3) @(negedge clk);
        check("rst_resp",   32'(mem_resp),  32'd0);
        check("rst_err",    32'(mem_err),   32'd0);
        check("rst_rdata",  mem_rdata,      32'd0);
        check("rst_resp1",  32'(mem_resp_1), 32'd0);
        rst = 1'b1;

        // Full write, then read back
        req3("t1_wr", 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 32'h0, 0);
        req3("t1_rd", 1, 0, 32'h10, 32'h0,        4'h0, 32'hDEADBEEF, 0);

        // Single-lane write with unaligned address bits
        req3("t2_wr", 0, 1, 32'h12, 32'h00AA0000, 4'b0100, 32'hDEADBEEF, 0);
        req3("t2_rd", 1, 0, 32'h10, 32'h0,        4'hF,    32'hDEAABEEF, 0);

        // Out-of-range accesses
        req3("t3_rdoor", 1, 0, 32'h1000, 32'h0,        4'h0, 32'h0,        1);
        req3("t3_wr0",   0, 1, 32'h0,    32'h0BADF00D, 4'hF, 32'h0,        0);
        req3("t3_wroor", 0, 1, 32'h1000, 32'h12345678, 4'hF, 32'h0,        1);
        req3("t3_rd0",   1, 0, 32'h0,    32'h0,        4'h0, 32'h0BADF00D, 0);

        // Write with no lanes enabled
        req3("be0_wr", 0, 1, 32'h0, 32'hFFFFFFFF, 4'h0, 32'h0BADF00D, 0);
        req3("be0_rd", 1, 0, 32'h0, 32'h0,        4'h0, 32'h0BADF00D, 0);

        // Both strobes high at the same time
        req3("t4_both", 1, 1, 32'h10, 32'h55555555, 4'hF, 32'h0BADF00D, 1);
        req3("t4_rd",   1, 0, 32'h10, 32'h0,        4'h0, 32'hDEAABEEF, 0);

        // Reset in the middle of a transaction
        req3("t5_pre", 0, 1, 32'h20, 32'h11223344, 4'hF, 32'hDEAABEEF, 0);
        @(negedge clk);
        mem_write = 1; mem_address = 32'h20; mem_wdata = 32'hCAFEF00D; mem_byte_enable = 4'hF;
        @(posedge clk);
        @(negedge clk);
        check("t5_busy_resp", 32'(mem_resp), 32'd0);
        rst = 1'b0;
        #1;
        check("t5_rst_rdata", mem_rdata, 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_rst_resp", 32'(mem_resp), 32'd0);
            check("t5_rst_err",  32'(mem_err),  32'd0);
        end
        mem_write = 0;
        rst = 1'b1;
        @(negedge clk);
        check("t5_post_resp", 32'(mem_resp), 32'd0);
        req3("t5_rd", 1, 0, 32'h20, 32'h0, 4'h0, 32'h11223344, 0);

        // LATENCY=1: seed a word, then hold mem_read continuously
        @(negedge clk);
        mem_write_1 = 1; mem_address_1 = 32'h40; mem_wdata_1 = 32'hA5A5A5A5; mem_byte_enable_1 = 4'hF;
        @(negedge clk);
        check("t6_wr_resp", 32'(mem_resp_1), 32'd1);
        check("t6_wr_err",  32'(mem_err_1),  32'd0);
        mem_write_1 = 0;
        @(negedge clk);
        mem_read_1 = 1;
        sb1.push_back(32'hA5A5A5A5);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            check("t6_resp", 32'(mem_resp_1), 32'(k % 2));
            if (mem_resp_1 === 1'b1) begin
                if (sb1.size() == 0) begin
                    check("t6_unexpected_resp", 32'd1, 32'(sb1.size()));
                end else begin
                    check("t6_rdata", mem_rdata_1, sb1.pop_front());
                end
            end else if (k < 10) begin
                sb1.push_back(32'hA5A5A5A5);
            end
        end
        mem_read_1 = 0;
        @(negedge clk);
        @(negedge clk);
        check("t6_idle_resp", 32'(mem_resp_1), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
